// File: rtl/pipe_stage_reg_pkg.sv
// Shared widths for the five-stage core's inter-stage registers.
// Provides the default payload/counter widths, per-stage payload widths and a stall predicate.
package pipe_stage_reg_pkg;

    localparam int unsigned WIDTH      = 32;
    localparam int unsigned DEF_DATA_W = WIDTH;
    localparam int unsigned DEF_CNT_W  = 16;

    typedef enum logic [1:0] {
        STG_IF_ID  = 2'd0,
        STG_ID_EX  = 2'd1,
        STG_EX_MEM = 2'd2,
        STG_MEM_WB = 2'd3
    } stage_e;

    // Concatenated payload width of each stage boundary, derived from the datapath width.
    function automatic int unsigned stage_data_w(input stage_e stg);
        case (stg)
            STG_IF_ID:  return 2 * WIDTH;
            STG_ID_EX:  return 4 * WIDTH + 16;
            STG_EX_MEM: return 3 * WIDTH + 8;
            STG_MEM_WB: return 2 * WIDTH + 8;
            default:    return WIDTH;
        endcase
    endfunction

    function automatic logic is_stall(input logic valid, input logic ready, input logic flush);
        return valid && !ready && !flush;
    endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid register (payload plus valid bit) for pipe_stage_reg.
// Only compiled when PIPE_SKID_EN is defined.
`ifdef PIPE_SKID_EN
module pipe_skid_buf #(
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned CLEAR_ON_FLUSH = 1
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clear,
    input  logic              i_load,
    input  logic              i_drain,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Skid entry: clear wins over load, load and drain never coincide.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
            if (CLEAR_ON_FLUSH != 0) begin
                r_data <= '0;
            end
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (i_drain) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`endif

// File: rtl/pipe_stage_reg.sv
// Valid/ready inter-stage pipeline register with flush-to-bubble and a saturating stall counter.
// Define PIPE_SKID_EN to add a one-entry skid register, giving a registered in_ready.
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int unsigned DATA_W         = DEF_DATA_W,
    parameter int unsigned CNT_W          = DEF_CNT_W,
    parameter int unsigned CLEAR_ON_FLUSH = 1
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    input  logic              flush,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [CNT_W-1:0]  r_stall_cnt;
    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_main_load;
    logic [DATA_W-1:0] w_main_next;

    assign w_out_fire = r_valid && out_ready;

`ifdef PIPE_SKID_EN
    logic              w_skid_valid;
    logic              w_skid_load;
    logic              w_skid_drain;
    logic [DATA_W-1:0] w_skid_data;

    assign in_ready     = !w_skid_valid;
    assign w_in_fire    = in_valid && !w_skid_valid;
    assign w_skid_load  = w_in_fire && r_valid && !out_ready;
    assign w_skid_drain = w_skid_valid && out_ready;

    pipe_skid_buf #(
        .DATA_W         (DATA_W),
        .CLEAR_ON_FLUSH (CLEAR_ON_FLUSH)
    ) u_skid (
        .i_clk   (sys_clk),
        .i_rst   (sys_rst),
        .i_clear (flush),
        .i_load  (w_skid_load),
        .i_drain (w_skid_drain),
        .i_data  (in_data),
        .o_valid (w_skid_valid),
        .o_data  (w_skid_data)
    );

    // Main register source: a full skid entry drains first so beats leave in order.
    always_comb begin
        w_main_load = 1'b0;
        w_main_next = in_data;
        if (w_skid_drain) begin
            w_main_load = 1'b1;
            w_main_next = w_skid_data;
        end else if (w_in_fire && !w_skid_load) begin
            w_main_load = 1'b1;
        end else begin
            w_main_load = 1'b0;
        end
    end
`else
    assign in_ready    = !r_valid || out_ready;
    assign w_in_fire   = in_valid && in_ready;
    assign w_main_load = w_in_fire;
    assign w_main_next = in_data;
`endif

    // Main register: flush squashes to a bubble ahead of any load or drain.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
            if (CLEAR_ON_FLUSH != 0) begin
                r_data <= '0;
            end
        end else if (w_main_load) begin
            r_valid <= 1'b1;
            r_data  <= w_main_next;
        end else if (w_out_fire) begin
            r_valid <= 1'b0;
        end
    end

    // Back-pressure counter: saturates at all-ones, cleared only by reset.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_stall_cnt <= '0;
        end else if (is_stall(r_valid, out_ready, flush) && (r_stall_cnt != CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Self-checking bench for pipe_stage_reg using a queue scoreboard as the reference model.
// A second instance with CNT_W=3 and CLEAR_ON_FLUSH=0 covers saturation and payload hold on flush.
module tb_pipe_stage_reg;

    localparam int unsigned DW     = 32;
    localparam int unsigned CW     = 16;
    localparam int unsigned CW_SAT = 3;
`ifdef PIPE_SKID_EN
    localparam int unsigned CAP = 2;
`else
    localparam int unsigned CAP = 1;
`endif

    logic          clk;
    logic          sys_rst;
    logic          in_valid;
    logic          out_ready;
    logic          flush;
    logic [DW-1:0] in_data;

    logic              in_ready;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic [CW-1:0]     stall_cnt;
    logic              s_in_ready;
    logic              s_out_valid;
    logic [DW-1:0]     s_out_data;
    logic [CW_SAT-1:0] s_stall_cnt;

    int n_cmp;
    int n_err;

    logic [DW-1:0] sb[$];
    logic [DW-1:0] m_data;
    logic [DW-1:0] m_data_s;
    int unsigned   m_cnt;
    int unsigned   m_cnt_s;
    bit            m_in_fire;

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW), .CLEAR_ON_FLUSH(1)) dut (
        .sys_clk(clk), .sys_rst(sys_rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .flush(flush), .stall_cnt(stall_cnt)
    );

    pipe_stage_reg #(.DATA_W(DW), .CNT_W(CW_SAT), .CLEAR_ON_FLUSH(0)) dut_sat (
        .sys_clk(clk), .sys_rst(sys_rst),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data),
        .flush(flush), .stall_cnt(s_stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bit m_in_ready();
        if (CAP == 2) return sb.size() < 2;
        else return (sb.size() == 0) || out_ready;
    endfunction

    // Advance one clock edge and update the scoreboard with the inputs presented.
    task automatic tick();
        bit in_fire;
        bit out_fire;
        bit stall;
        in_fire   = in_valid && m_in_ready();
        out_fire  = (sb.size() > 0) && out_ready;
        stall     = (sb.size() > 0) && !out_ready && !flush;
        m_in_fire = in_fire && !sys_rst;
        @(posedge clk);
        if (sys_rst) begin
            sb.delete();
            m_data   = '0;
            m_data_s = '0;
            m_cnt    = 0;
            m_cnt_s  = 0;
        end else begin
            if (stall) begin
                if (m_cnt < ((1 << CW) - 1)) m_cnt++;
                if (m_cnt_s < ((1 << CW_SAT) - 1)) m_cnt_s++;
            end
            if (flush) begin
                sb.delete();
                m_data = '0;
            end else begin
                if (out_fire) void'(sb.pop_front());
                if (in_fire) sb.push_back(in_data);
                if (sb.size() > 0) begin
                    m_data   = sb[0];
                    m_data_s = sb[0];
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic set_in(input bit v, input logic [DW-1:0] d, input bit r, input bit f);
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        flush     = f;
        #1;
    endtask

    task automatic do_reset();
        sys_rst = 1'b1;
        set_in(1'b0, '0, 1'b0, 1'b0);
        tick();
        sys_rst = 1'b0;
    endtask

    task automatic test_reset();
        sys_rst = 1'b1;
        set_in(1'b1, 32'h1234, 1'b0, 1'b0);
        tick();
        tick();
        sys_rst = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        n_cmp++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL reset_stall_cnt: got %0d want 0", stall_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (s_out_data !== 32'h0) begin n_err++; $display("FAIL reset_out_data_noclear: got %h want 0", s_out_data); end
    endtask

    task automatic test_streaming();
        logic [DW-1:0] exp;
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            set_in(1'b1, DW'(i), 1'b1, 1'b0);
            n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL stream_in_ready[%0d]: got %b want 1", i, in_ready); end
            tick();
            exp = (sb.size() > 0) ? sb[0] : 32'hFFFF_FFFF;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== exp) begin
                n_err++; $display("FAIL stream_out[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid, out_data, exp);
            end
        end
        set_in(1'b0, '0, 1'b1, 1'b0);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stream_drain_valid: got %b want 0", out_valid); end
        n_cmp++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL stream_stall_cnt: got %0d want 0", stall_cnt); end
    endtask

    task automatic test_back_pressure();
        bit pend;
        bit exp_rdy;
        do_reset();
        set_in(1'b1, 32'hA5, 1'b0, 1'b0);
        tick();
        pend = 1'b1;
        for (int c = 0; c < 5; c++) begin
            set_in(pend, 32'h5A, 1'b0, 1'b0);
            exp_rdy = (CAP == 2) && (c == 0);
            n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b want %b", c, in_ready, exp_rdy); end
            tick();
            if (m_in_fire) pend = 1'b0;
            n_cmp++;
            if (out_valid !== 1'b1 || out_data !== 32'hA5) begin
                n_err++; $display("FAIL bp_hold[%0d]: got v=%b d=%h want v=1 d=a5", c, out_valid, out_data);
            end
        end
        n_cmp++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL bp_stall_cnt: got %0d want 5", stall_cnt); end
        set_in(pend, 32'h5A, 1'b1, 1'b0);
        exp_rdy = (CAP == 1);
        n_cmp++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL bp_release_ready: got %b want %b", in_ready, exp_rdy); end
        tick();
        if (m_in_fire) pend = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 32'h5A) begin
            n_err++; $display("FAIL bp_second_beat: got v=%b d=%h want v=1 d=5a", out_valid, out_data);
        end
        set_in(1'b0, '0, 1'b1, 1'b0);
        tick();
        n_cmp++; if (out_valid !== 1'b0 || pend) begin n_err++; $display("FAIL bp_empty: got v=%b pend=%b want v=0 pend=0", out_valid, pend); end
        n_cmp++; if (stall_cnt !== 16'd5) begin n_err++; $display("FAIL bp_stall_after: got %0d want 5", stall_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        set_in(1'b1, 32'hDEAD, 1'b0, 1'b0);
        tick();
        set_in(1'b1, 32'hBEEF, 1'b0, 1'b1);
        tick();
        set_in(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0) begin n_err++; $display("FAIL flush_data_clear: got %h want 0", out_data); end
        n_cmp++; if (s_out_data !== 32'hDEAD) begin n_err++; $display("FAIL flush_data_hold: got %h want dead", s_out_data); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %b want 1", in_ready); end
        n_cmp++; if (stall_cnt !== 16'h0) begin n_err++; $display("FAIL flush_stall_cnt: got %0d want 0", stall_cnt); end
        for (int c = 0; c < 3; c++) begin
            set_in(1'b0, '0, 1'b1, 1'b0);
            tick();
            n_cmp++;
            if (out_valid !== 1'b0 || out_data !== 32'h0) begin
                n_err++; $display("FAIL flush_no_beef[%0d]: got v=%b d=%h want v=0 d=0", c, out_valid, out_data);
            end
        end
    endtask

    task automatic test_saturation();
        int unsigned exp_s;
        do_reset();
        set_in(1'b1, 32'h77, 1'b0, 1'b0);
        tick();
        for (int c = 1; c <= 10; c++) begin
            set_in(1'b0, '0, 1'b0, 1'b0);
            tick();
            exp_s = (c < 7) ? c : 7;
            n_cmp++; if (s_stall_cnt !== CW_SAT'(exp_s)) begin n_err++; $display("FAIL sat_cnt3[%0d]: got %0d want %0d", c, s_stall_cnt, exp_s); end
            n_cmp++; if (stall_cnt !== CW'(c)) begin n_err++; $display("FAIL sat_cnt16[%0d]: got %0d want %0d", c, stall_cnt, c); end
        end
    endtask

    task automatic test_reset_mid();
        sys_rst = 1'b1;
        set_in(1'b1, 32'h99, 1'b0, 1'b0);
        tick();
        sys_rst = 1'b0;
        set_in(1'b0, '0, 1'b0, 1'b0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_data !== 32'h0 || s_out_data !== 32'h0) begin n_err++; $display("FAIL rstmid_data: got %h/%h want 0/0", out_data, s_out_data); end
        n_cmp++; if (stall_cnt !== 16'h0 || s_stall_cnt !== 3'h0) begin n_err++; $display("FAIL rstmid_cnt: got %0d/%0d want 0/0", stall_cnt, s_stall_cnt); end
        n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %b want 1", in_ready); end
        set_in(1'b0, '0, 1'b1, 1'b0);
        tick();
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_no_beat: got %b want 0", out_valid); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 300; c++) begin
            set_in($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 15) == 0);
            n_cmp++;
            if (in_ready !== m_in_ready()) begin
                n_err++; $display("FAIL rand_in_ready[%0d]: got %b want %b", c, in_ready, m_in_ready());
            end
            n_cmp++;
            if (out_valid !== (sb.size() > 0) || out_data !== m_data || stall_cnt !== CW'(m_cnt)) begin
                n_err++; $display("FAIL rand_out[%0d]: got v=%b d=%h cnt=%0d want v=%0d d=%h cnt=%0d",
                                  c, out_valid, out_data, stall_cnt, sb.size() > 0, m_data, m_cnt);
            end
            n_cmp++;
            if (s_out_data !== m_data_s || s_stall_cnt !== CW_SAT'(m_cnt_s)) begin
                n_err++; $display("FAIL rand_sat[%0d]: got d=%h cnt=%0d want d=%h cnt=%0d",
                                  c, s_out_data, s_stall_cnt, m_data_s, m_cnt_s);
            end
            tick();
        end
    endtask

    initial begin
        n_cmp     = 0;
        n_err     = 0;
        m_data    = '0;
        m_data_s  = '0;
        m_cnt     = 0;
        m_cnt_s   = 0;
        m_in_fire = 1'b0;
        sys_rst   = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        flush     = 1'b0;
        @(negedge clk);
        test_reset();
        test_streaming();
        test_back_pressure();
        test_flush();
        test_saturation();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
